// File: rtl/gen3_tx_framer.sv
// ---------------------------------------------------------------------------
// gen3_tx_framer
//   Builds a Gen3-style framed byte stream from a TLP source and a DLLP
//   source. Each clock emits exactly one registered byte. The output byte is
//   the one belonging to the FSM state of the previous cycle. A TLP frame is
//   STP (4 bytes), then len*4 payload bytes, then a terminator. A DLLP frame
//   is SDP (2 bytes), then 6 payload bytes, then a terminator. DLLPs win when
//   both sources request a frame at the same time.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   tlp_valid    TLP byte/header available
//   tlp_data     TLP payload byte
//   tlp_len_dw   TLP length in DW (sampled at frame start)
//   tlp_nullify  request EDB termination (sampled at frame start)
//   tlp_ready    TLP payload byte accepted this cycle
//   dllp_valid   DLLP byte available
//   dllp_data    DLLP byte
//   dllp_ready   DLLP payload byte accepted this cycle
//   out_data     framed byte
//   out_valid    byte strobe (high every cycle out of reset)
//   out_sync     sync header (2'b01 out of reset)
//   out_type     one-hot byte classification
//   err_underrun pulses for a payload byte whose source was not valid
// ---------------------------------------------------------------------------
module gen3_tx_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tlp_valid,
    input  logic [7:0] tlp_data,
    input  logic [9:0] tlp_len_dw,
    input  logic       tlp_nullify,
    output logic       tlp_ready,
    input  logic       dllp_valid,
    input  logic [7:0] dllp_data,
    output logic       dllp_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [1:0] out_sync,
    output logic [5:0] out_type,
    output logic       err_underrun
);

    localparam logic [5:0] TY_DATA   = 6'b100000;
    localparam logic [5:0] TY_TSTART = 6'b010000;
    localparam logic [5:0] TY_TEND   = 6'b001000;
    localparam logic [5:0] TY_DEND   = 6'b000100;
    localparam logic [5:0] TY_DSTART = 6'b000010;
    localparam logic [5:0] TY_TEDB   = 6'b000001;
    localparam logic [5:0] TY_NONE   = 6'b000000;

    typedef enum logic [3:0] {
        IDLE, STP0, STP1, STP2, STP3, TPAY, TEND, SDP0, SDP1, DPAY, DEND
    } state_e;

    state_e      state_q, state_d;
    state_e      frame_sel;
    logic [11:0] cnt_q, cnt_d;
    logic [9:0]  len_q, len_d;
    logic        nul_q, nul_d;
    logic        underrun_q, underrun_d;

    logic [7:0]  out_data_d;
    logic [5:0]  out_type_d;
    logic        err_underrun_d;
    logic [11:0] tlp_bytes;

    assign tlp_bytes = {len_q, 2'b00};

    // Ready is gated by reset so it is low for the whole time rst is held,
    // even on the first reset edge while state_q may still be a payload state.
    assign tlp_ready  = rst & (state_q == TPAY);
    assign dllp_ready = rst & (state_q == DPAY);

    always_comb begin
        frame_sel = IDLE;
        if (dllp_valid) begin
            frame_sel = SDP0;
        end else if (tlp_valid) begin
            frame_sel = STP0;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        nul_d          = nul_q;
        underrun_d     = underrun_q;
        out_data_d     = 8'h00;
        out_type_d     = TY_NONE;
        err_underrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = frame_sel;
            end
            STP0: begin
                out_data_d = {len_q[3:0], 4'hF};
                state_d    = STP1;
            end
            STP1: begin
                out_data_d = {2'b00, len_q[9:4]};
                state_d    = STP2;
            end
            STP2: begin
                state_d = STP3;
            end
            STP3: begin
                out_type_d = TY_TSTART;
                cnt_d      = '0;
                state_d    = (len_q == '0) ? TEND : TPAY;
            end
            TPAY: begin
                out_type_d = TY_DATA;
                if (tlp_valid) begin
                    out_data_d = tlp_data;
                end else begin
                    err_underrun_d = 1'b1;
                    underrun_d     = 1'b1;
                end
                if ((cnt_q + 12'd1) == tlp_bytes) begin
                    cnt_d   = '0;
                    state_d = TEND;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            TEND: begin
                if (nul_q || underrun_q) begin
                    out_data_d = 8'hC0;
                    out_type_d = TY_TEDB;
                end else begin
                    out_type_d = TY_TEND;
                end
                underrun_d = 1'b0;
                state_d    = frame_sel;
            end
            SDP0: begin
                out_data_d = 8'hF0;
                state_d    = SDP1;
            end
            SDP1: begin
                out_data_d = 8'hAC;
                out_type_d = TY_DSTART;
                cnt_d      = '0;
                state_d    = DPAY;
            end
            DPAY: begin
                out_type_d = TY_DATA;
                if (dllp_valid) begin
                    out_data_d = dllp_data;
                end else begin
                    err_underrun_d = 1'b1;
                end
                if (cnt_q == 12'd5) begin
                    cnt_d   = '0;
                    state_d = DEND;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            DEND: begin
                out_type_d = TY_DEND;
                state_d    = frame_sel;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // STP0 is only reachable from a frame decision, so this is exactly
        // the frame-start moment when the header fields are captured.
        if (state_d == STP0) begin
            len_d = tlp_len_dw;
            nul_d = tlp_nullify;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            nul_q        <= 1'b0;
            underrun_q   <= 1'b0;
            out_data     <= 8'h00;
            out_valid    <= 1'b0;
            out_sync     <= 2'b00;
            out_type     <= TY_NONE;
            err_underrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            nul_q        <= nul_d;
            underrun_q   <= underrun_d;
            out_data     <= out_data_d;
            out_valid    <= 1'b1;
            out_sync     <= 2'b01;
            out_type     <= out_type_d;
            err_underrun <= err_underrun_d;
        end
    end

endmodule

// File: tb/tb_gen3_tx_framer.sv
module tb_gen3_tx_framer;

    localparam logic [5:0] T_DATA   = 6'b100000;
    localparam logic [5:0] T_TSTART = 6'b010000;
    localparam logic [5:0] T_TEND   = 6'b001000;
    localparam logic [5:0] T_DEND   = 6'b000100;
    localparam logic [5:0] T_DSTART = 6'b000010;
    localparam logic [5:0] T_TEDB   = 6'b000001;
    localparam logic [5:0] T_NONE   = 6'b000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tlp_valid;
    logic [7:0] tlp_data;
    logic [9:0] tlp_len_dw;
    logic       tlp_nullify;
    logic       tlp_ready;
    logic       dllp_valid;
    logic [7:0] dllp_data;
    logic       dllp_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic [1:0] out_sync;
    logic [5:0] out_type;
    logic       err_underrun;

    gen3_tx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .tlp_valid    (tlp_valid),
        .tlp_data     (tlp_data),
        .tlp_len_dw   (tlp_len_dw),
        .tlp_nullify  (tlp_nullify),
        .tlp_ready    (tlp_ready),
        .dllp_valid   (dllp_valid),
        .dllp_data    (dllp_data),
        .dllp_ready   (dllp_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_sync     (out_sync),
        .out_type     (out_type),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [5:0] typ;
        logic       err;
        logic       vld;
        logic [1:0] sync;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_tr   = 1'b0;
    logic exp_dr   = 1'b0;

    function automatic exp_t mk(input logic [7:0] d, input logic [5:0] t, input logic e);
        exp_t r;
        r.data = d;
        r.typ  = t;
        r.err  = e;
        r.vld  = 1'b1;
        r.sync = 2'b01;
        return r;
    endfunction

    function automatic exp_t mk_reset();
        exp_t r;
        r.data = 8'h00;
        r.typ  = T_NONE;
        r.err  = 1'b0;
        r.vld  = 1'b0;
        r.sync = 2'b00;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and compare every output against the next expected
    // byte (an idle byte when nothing is queued).
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = mk(8'h00, T_NONE, 1'b0);
        chk("out_data",     32'(out_data),     32'(e.data));
        chk("out_type",     32'(out_type),     32'(e.typ));
        chk("err_underrun", 32'(err_underrun), 32'(e.err));
        chk("out_valid",    32'(out_valid),    32'(e.vld));
        chk("out_sync",     32'(out_sync),     32'(e.sync));
        chk("tlp_ready",    32'(tlp_ready),    32'(exp_tr));
        chk("dllp_ready",   32'(dllp_ready),   32'(exp_dr));
    endtask

    // Entered just after a clock edge that left the DUT in a decision state.
    // lead: that state is IDLE (its byte is still to come); otherwise the
    // previous frame's terminator is already queued. chain: return while the
    // DUT sits in TEND so the caller can start the next frame back-to-back.
    task automatic send_tlp(input bit lead, input bit chain, input int len, input bit nul,
                            input int base, input int drop_at, input bit rnd_drop,
                            input int abort_at);
        logic [7:0] pl [4092];
        bit         drop [4092];
        logic [9:0] lv;
        int         n;
        bit         any;
        lv  = 10'(len);
        n   = len * 4;
        any = 0;
        for (int i = 0; i < n; i++) begin
            pl[i]   = (base >= 0) ? 8'(base + i) : 8'($urandom);
            drop[i] = (i == drop_at) || (rnd_drop && ($urandom_range(0, 5) == 0));
            any     = any | drop[i];
        end
        if (lead) exp_q.push_back(mk(8'h00, T_NONE, 1'b0));
        exp_q.push_back(mk({lv[3:0], 4'hF}, T_NONE, 1'b0));
        exp_q.push_back(mk({2'b00, lv[9:4]}, T_NONE, 1'b0));
        exp_q.push_back(mk(8'h00, T_NONE, 1'b0));
        exp_q.push_back(mk(8'h00, T_TSTART, 1'b0));
        for (int i = 0; i < n; i++) begin
            if (drop[i]) exp_q.push_back(mk(8'h00, T_DATA, 1'b1));
            else         exp_q.push_back(mk(pl[i], T_DATA, 1'b0));
        end
        if (nul || any) exp_q.push_back(mk(8'hC0, T_TEDB, 1'b0));
        else            exp_q.push_back(mk(8'h00, T_TEND, 1'b0));

        tlp_valid   = 1'b1;
        tlp_len_dw  = lv;
        tlp_nullify = nul;
        tlp_data    = 8'($urandom);
        exp_tr      = 1'b0;
        cycle();
        // header fields must already be captured; scramble them
        tlp_len_dw  = 10'($urandom);
        tlp_nullify = 1'($urandom);
        cycle();
        cycle();
        cycle();
        exp_tr = (n > 0);
        cycle();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 1'b0;
                #1;
                chk("tlp_ready_in_reset", 32'(tlp_ready), 32'd0);
                exp_q.delete();
                exp_q.push_back(mk_reset());
                exp_tr = 1'b0;
                cycle();
                rst       = 1'b1;
                tlp_valid = 1'b0;
                cycle();
                return;
            end
            tlp_valid = !drop[i];
            tlp_data  = drop[i] ? 8'($urandom) : pl[i];
            exp_tr    = (i < n - 1);
            cycle();
        end
        tlp_valid = 1'b0;
        if (!chain) cycle();
    endtask

    task automatic send_dllp(input bit lead, input bit chain, input int base,
                             input int drop_at, input bit rnd_drop);
        logic [7:0] pl [6];
        bit         drop [6];
        for (int i = 0; i < 6; i++) begin
            pl[i]   = (base >= 0) ? 8'(base + i) : 8'($urandom);
            drop[i] = (i == drop_at) || (rnd_drop && ($urandom_range(0, 4) == 0));
        end
        if (lead) exp_q.push_back(mk(8'h00, T_NONE, 1'b0));
        exp_q.push_back(mk(8'hF0, T_NONE, 1'b0));
        exp_q.push_back(mk(8'hAC, T_DSTART, 1'b0));
        for (int i = 0; i < 6; i++) begin
            if (drop[i]) exp_q.push_back(mk(8'h00, T_DATA, 1'b1));
            else         exp_q.push_back(mk(pl[i], T_DATA, 1'b0));
        end
        exp_q.push_back(mk(8'h00, T_DEND, 1'b0));

        dllp_valid = 1'b1;
        dllp_data  = 8'($urandom);
        exp_dr     = 1'b0;
        cycle();
        cycle();
        exp_dr = 1'b1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            dllp_valid = !drop[i];
            dllp_data  = drop[i] ? 8'($urandom) : pl[i];
            exp_dr     = (i < 5);
            cycle();
        end
        dllp_valid = 1'b0;
        if (!chain) cycle();
    endtask

    initial begin
        bit prev_chain;
        bit ch;
        rst         = 1'b0;
        tlp_valid   = 1'b0;
        tlp_data    = 8'h00;
        tlp_len_dw  = 10'd0;
        tlp_nullify = 1'b0;
        dllp_valid  = 1'b0;
        dllp_data   = 8'h00;

        // reset state
        exp_q.push_back(mk_reset());
        exp_q.push_back(mk_reset());
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();

        // len=1, data A1..A4, clean terminator
        send_tlp(1, 0, 1, 0, 8'hA1, -1, 0, -1);
        // DLLP 11..16
        send_dllp(1, 0, 8'h11, -1, 0);
        // both requesting at once: DLLP first, TLP right after DEND
        tlp_valid  = 1'b1;
        tlp_len_dw = 10'd1;
        send_dllp(1, 1, 8'h21, -1, 0);
        send_tlp(0, 0, 1, 0, 8'h31, -1, 0, -1);
        // underrun on third payload byte of a len=2 TLP
        send_tlp(1, 0, 2, 0, 8'h40, 2, 0, -1);
        // nullified long TLP
        send_tlp(1, 0, 10'h123, 1, -1, -1, 0, -1);
        // zero-length TLP goes straight to the terminator
        send_tlp(1, 0, 0, 0, -1, -1, 0, -1);
        // DLLP underrun: data byte 00 with error pulse, normal terminator
        send_dllp(1, 0, 8'h50, 3, 0);
        // reset in the middle of the payload, then a fresh frame
        send_tlp(1, 0, 2, 0, 8'h60, -1, 0, 2);
        send_tlp(1, 0, 1, 0, 8'h70, -1, 0, -1);
        // TLP followed immediately by a TLP, then by a DLLP
        send_tlp(1, 1, 1, 0, 8'h80, -1, 0, -1);
        send_tlp(0, 1, 2, 0, 8'h90, -1, 0, -1);
        send_dllp(0, 0, 8'hB0, -1, 0);

        // randomized frames with random chaining, gaps and underruns
        prev_chain = 0;
        for (int it = 0; it < 30; it++) begin
            ch = (it < 29) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                send_tlp(!prev_chain, ch, $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                         -1, -1, 1, -1);
            else
                send_dllp(!prev_chain, ch, -1, -1, 1);
            if (!ch) begin
                repeat ($urandom_range(0, 2)) cycle();
            end
            prev_chain = ch;
        end
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
